bvh_trav_ctrl: RTL and testbench
================================

// Module: bvh_trav_ctrl
// PURPOSE
//  Per-ray BVH traversal controller; consumes hit/range_out of ray_bbox_intersect and decides the next node to test.
//  Issues node indices with the current [tmin,tmax] range as prev_range and keeps a LIFO stack of deferred siblings.
//  Forwards hit leaves to the primitive-test stage and tightens tmax from reported closest hits. One ray in flight.
// PARAMETERS
//  NODE_IDX_W   16  node/primitive index width
//  STACK_DEPTH  16  deferred-node stack entries (power of 2)
//  CNT_W        4   leaf primitive-count width
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous active-low reset
//  ray_valid    in   1        new ray available
//  ray_ready    out  1        controller idle, accepts ray
//  root_idx     in   NODE_IDX_W  BVH root node
//  ray_range    in   range    initial {min,max}, signed 49b each
//  node_valid   out  1        node issue to fetch/intersect
//  node_ready   in   1        downstream accepts (stall = ~node_ready)
//  node_idx     out  NODE_IDX_W  node to test
//  node_range   out  range    prev_range for the box test
//  res_valid    in   1        box-test result for last issued node
//  res_hit      in   1        intersect hit
//  res_range    in   range    intersect range_out
//  res_is_leaf  in   1        tested node is a leaf
//  res_first    in   NODE_IDX_W  first child (inner) / first prim (leaf)
//  res_count    in   CNT_W    leaf primitive count
//  leaf_valid   out  1        leaf to primitive stage
//  leaf_ready   in   1        primitive stage accepts
//  leaf_first   out  NODE_IDX_W  first primitive
//  leaf_count   out  CNT_W    primitive count
//  leaf_range   out  range    clipped range for the leaf
//  tclose_valid in   1        primitive stage reports a hit
//  tclose       in   49 s     hit distance
//  done         out  1        1-cycle pulse: traversal finished
//  overflow     out  1        sticky: a push was dropped this ray
// BEHAVIOUR
//  Reset: state IDLE; ray_ready=1; node_valid=leaf_valid=done=overflow=0; stack empty; cur range 0.
//  FSM: IDLE -> ISSUE -> WAIT -> {ISSUE | LEAF | POP}; LEAF -> POP; POP -> {ISSUE | POP | DONE}; DONE -> IDLE.
//  IDLE: ray_valid&ray_ready latches root_idx, ray_range into cur_idx/cur_rng, clears overflow -> ISSUE.
//  ISSUE: node_valid=1, outputs stable until node_ready; handshake -> WAIT.
//  WAIT: res_valid with res_hit=0 -> POP. res_hit & inner: push {res_first+1, res_range.min},
//   cur_idx=res_first, cur_rng.min=res_range.min -> ISSUE. res_hit & leaf -> LEAF, leaf_range=res_range.
//  res_valid outside WAIT is ignored.
//  LEAF: leaf_valid=1 held until leaf_ready -> POP.
//  POP: empty -> DONE. Else pop {idx,tmin}; tmin >= cur_rng.max culls it (1 cycle, stay POP);
//   else cur_idx=idx, cur_rng.min=tmin -> ISSUE.
//  DONE: done=1 one cycle, ray_ready=0 -> IDLE (ray_ready=1 next cycle).
//  tclose: in any non-IDLE state, tclose_valid & tclose < cur_rng.max loads cur_rng.max=tclose next cycle.
//   A same-cycle POP cull compare uses the pre-update registered max.
//  Full stack on push: entry dropped, overflow<=1, traversal continues.
//  Comparisons are signed 49b; no saturation needed. Push and pop never coincide.
//  Reset mid-ray: abandon state, clear stack pointer; outputs return to reset values asynchronously.
// CONFIGURATION
//  BVH_TRAV_STATS_EN defined: adds outputs stat_nodes (32b, issue handshakes) and stat_leaves (32b, leaf handshakes).
//   Both clear on ray accept and hold after done.
//  Not defined: ports and counters are absent; no other behaviour changes.
// STRUCTURE
//  Shared package: range/vec typedefs (existing), T_W=49, trav_state_t enum, stack_entry_t {idx,tmin}.
//  Sub-module bvh_trav_stack: LIFO, sync push/pop, full/empty, async active-low reset of pointer only.
// TESTING
//  Root miss: ray_range{0,1000}, res_hit=0 -> POP, done pulses after 1 node issue; leaf_valid never set.
//  Root inner hit, res_first=4 -> node_idx=4 issued next; after miss, pop issues 5 with min=res_range.min.
//  Leaf hit first=20,count=3 with leaf_ready low 5 cycles -> leaf_valid held 5 cycles, fields stable.
//  Stack entry tmin=300, tclose=250 before pop -> entry culled, no issue, done next cycle.
//  17 nested inner hits, STACK_DEPTH=16 -> overflow=1, traversal still reaches done.
//  node_ready low 3 cycles in ISSUE; rst_n low in WAIT -> state IDLE, ray_ready=1, overflow=0.

Source files
------------

// File: rtl/bvh_trav_ctrl_pkg.sv
// rtl/bvh_trav_ctrl_pkg.sv - shared types for the BVH traversal controller
package bvh_trav_ctrl_pkg;

    localparam int T_W   = 49;
    localparam int IDX_W = 16;

    typedef logic signed [T_W-1:0] t_val_t;

    typedef struct packed {
        t_val_t min;
        t_val_t max;
    } range_t;

    typedef struct packed {
        t_val_t x;
        t_val_t y;
        t_val_t z;
    } vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_LEAF,
        ST_POP,
        ST_DONE
    } trav_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        t_val_t           tmin;
    } stack_entry_t;

endpackage

// File: rtl/bvh_trav_ctrl_if.sv
// rtl/bvh_trav_ctrl_if.sv - ray, node, result, leaf and tclose channels of the traversal controller
interface bvh_trav_ctrl_if
    import bvh_trav_ctrl_pkg::*;
#(
    parameter int NODE_IDX_W = 16,
    parameter int CNT_W      = 4
);
    logic                  ray_valid;
    logic                  ray_ready;
    logic [NODE_IDX_W-1:0] root_idx;
    range_t                ray_range;

    logic                  node_valid;
    logic                  node_ready;
    logic [NODE_IDX_W-1:0] node_idx;
    range_t                node_range;

    logic                  res_valid;
    logic                  res_hit;
    range_t                res_range;
    logic                  res_is_leaf;
    logic [NODE_IDX_W-1:0] res_first;
    logic [CNT_W-1:0]      res_count;

    logic                  leaf_valid;
    logic                  leaf_ready;
    logic [NODE_IDX_W-1:0] leaf_first;
    logic [CNT_W-1:0]      leaf_count;
    range_t                leaf_range;

    logic                  tclose_valid;
    t_val_t                tclose;
    logic                  done;
    logic                  overflow;

    modport master (
        input  ray_valid, root_idx, ray_range, node_ready,
               res_valid, res_hit, res_range, res_is_leaf, res_first, res_count,
               leaf_ready, tclose_valid, tclose,
        output ray_ready, node_valid, node_idx, node_range,
               leaf_valid, leaf_first, leaf_count, leaf_range, done, overflow
    );

    modport slave (
        output ray_valid, root_idx, ray_range, node_ready,
               res_valid, res_hit, res_range, res_is_leaf, res_first, res_count,
               leaf_ready, tclose_valid, tclose,
        input  ray_ready, node_valid, node_idx, node_range,
               leaf_valid, leaf_first, leaf_count, leaf_range, done, overflow
    );
endinterface

// File: rtl/bvh_trav_ctrl_stack.sv
// rtl/bvh_trav_ctrl_stack.sv - LIFO of deferred siblings; only the pointer is reset
module bvh_trav_stack #(
    parameter int DATA_W = 65,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [AW:0]       cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     top_ptr;

    // DEPTH is a power of two, so the count MSB alone means full
    assign full_o     = cnt_q[AW];
    assign empty_o    = (cnt_q == '0);
    assign top_ptr    = cnt_q[AW-1:0] - PTR_ONE;
    assign pop_data_o = mem_q[top_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + CNT_ONE;
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[cnt_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/bvh_trav_ctrl.sv
// rtl/bvh_trav_ctrl.sv - per-ray BVH traversal controller with deferred-sibling stack
// Optional BVH_TRAV_STATS_EN adds stat_nodes/stat_leaves handshake counters.
module bvh_trav_ctrl
    import bvh_trav_ctrl_pkg::*;
#(
    parameter int NODE_IDX_W  = 16,
    parameter int STACK_DEPTH = 16,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bvh_trav_ctrl_if.master    bus
`ifdef BVH_TRAV_STATS_EN
    ,
    output logic [31:0]        stat_nodes,
    output logic [31:0]        stat_leaves
`endif
);
    localparam int SE_W = NODE_IDX_W + T_W;
    localparam logic [NODE_IDX_W-1:0] IDX_ONE = 1;

    trav_state_t           state_q, state_d;
    logic [NODE_IDX_W-1:0] cur_idx_q, cur_idx_d;
    range_t                cur_rng_q, cur_rng_d;
    logic [NODE_IDX_W-1:0] leaf_first_q, leaf_first_d;
    logic [CNT_W-1:0]      leaf_count_q, leaf_count_d;
    range_t                leaf_range_q, leaf_range_d;
    logic                  overflow_q, overflow_d;

    logic                  push, pop, full, empty;
    logic [SE_W-1:0]       push_data, pop_data;
    logic [NODE_IDX_W-1:0] pop_idx;
    t_val_t                pop_tmin;

    assign push_data           = {bus.res_first + IDX_ONE, bus.res_range.min};
    assign {pop_idx, pop_tmin} = pop_data;

    bvh_trav_stack #(.DATA_W(SE_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        cur_rng_d    = cur_rng_q;
        leaf_first_d = leaf_first_q;
        leaf_count_d = leaf_count_q;
        leaf_range_d = leaf_range_q;
        overflow_d   = overflow_q;
        push         = 1'b0;
        pop          = 1'b0;

        // Closest-hit tightening runs alongside whatever the FSM does with min
        if (state_q != ST_IDLE && bus.tclose_valid && (bus.tclose < cur_rng_q.max)) begin
            cur_rng_d.max = bus.tclose;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.ray_valid) begin
                    cur_idx_d  = bus.root_idx;
                    cur_rng_d  = bus.ray_range;
                    overflow_d = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.node_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.res_valid) begin
                    if (!bus.res_hit) begin
                        state_d = ST_POP;
                    end else if (bus.res_is_leaf) begin
                        leaf_first_d = bus.res_first;
                        leaf_count_d = bus.res_count;
                        leaf_range_d = bus.res_range;
                        state_d      = ST_LEAF;
                    end else begin
                        push = 1'b1;
                        if (full) overflow_d = 1'b1;
                        cur_idx_d     = bus.res_first;
                        cur_rng_d.min = bus.res_range.min;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_LEAF: begin
                if (bus.leaf_ready) state_d = ST_POP;
            end
            ST_POP: begin
                if (empty) begin
                    state_d = ST_DONE;
                end else begin
                    pop = 1'b1;
                    if (pop_tmin < cur_rng_q.max) begin
                        cur_idx_d     = pop_idx;
                        cur_rng_d.min = pop_tmin;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_idx_q    <= '0;
            cur_rng_q    <= '0;
            leaf_first_q <= '0;
            leaf_count_q <= '0;
            leaf_range_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            cur_rng_q    <= cur_rng_d;
            leaf_first_q <= leaf_first_d;
            leaf_count_q <= leaf_count_d;
            leaf_range_q <= leaf_range_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.ray_ready  = (state_q == ST_IDLE);
    assign bus.node_valid = (state_q == ST_ISSUE);
    assign bus.node_idx   = cur_idx_q;
    assign bus.node_range = cur_rng_q;
    assign bus.leaf_valid = (state_q == ST_LEAF);
    assign bus.leaf_first = leaf_first_q;
    assign bus.leaf_count = leaf_count_q;
    assign bus.leaf_range = leaf_range_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.overflow   = overflow_q;

`ifdef BVH_TRAV_STATS_EN
    logic [31:0] stat_nodes_q, stat_leaves_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_nodes_q  <= '0;
            stat_leaves_q <= '0;
        end else if (state_q == ST_IDLE && bus.ray_valid) begin
            stat_nodes_q  <= '0;
            stat_leaves_q <= '0;
        end else begin
            if (bus.node_valid && bus.node_ready) stat_nodes_q  <= stat_nodes_q + 32'd1;
            if (bus.leaf_valid && bus.leaf_ready) stat_leaves_q <= stat_leaves_q + 32'd1;
        end
    end

    assign stat_nodes  = stat_nodes_q;
    assign stat_leaves = stat_leaves_q;
`endif
endmodule

// File: tb/tb_bvh_trav_ctrl.sv
// tb/tb_bvh_trav_ctrl.sv - scoreboard bench for bvh_trav_ctrl
module tb_bvh_trav_ctrl;
    import bvh_trav_ctrl_pkg::*;

    typedef struct {
        logic [15:0] idx;
        t_val_t      mn;
        t_val_t      mx;
    } node_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    node_exp_t exp_q[$];

    bvh_trav_ctrl_if #(.NODE_IDX_W(16), .CNT_W(4)) bus ();

`ifdef BVH_TRAV_STATS_EN
    logic [31:0] stat_nodes, stat_leaves;
    bvh_trav_ctrl #(.NODE_IDX_W(16), .STACK_DEPTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .stat_nodes(stat_nodes), .stat_leaves(stat_leaves)
    );
`else
    bvh_trav_ctrl #(.NODE_IDX_W(16), .STACK_DEPTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
`endif

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_exp(int idx, longint mn, longint mx);
        node_exp_t e;
        e.idx = 16'(idx);
        e.mn  = t_val_t'(mn);
        e.mx  = t_val_t'(mx);
        exp_q.push_back(e);
    endtask

    task automatic start_ray(int root, longint mn, longint mx);
        int n = 0;
        while (bus.ray_ready !== 1'b1 && n < 20) begin cyc(); n++; end
        checks++;
        if (bus.ray_ready !== 1'b1) begin
            errors++;
            $display("FAIL ray_ready_timeout: ray_ready=%b required 1", bus.ray_ready);
        end
        bus.ray_valid = 1'b1;
        bus.root_idx  = 16'(root);
        bus.ray_range.min = t_val_t'(mn);
        bus.ray_range.max = t_val_t'(mx);
        cyc();
        bus.ray_valid = 1'b0;
    endtask

    task automatic accept_node();
        int n = 0;
        node_exp_t e;
        while (bus.node_valid !== 1'b1 && n < 50) begin cyc(); n++; end
        checks++;
        if (bus.node_valid !== 1'b1) begin
            errors++;
            $display("FAIL node_issue_timeout: node_valid=%b required 1", bus.node_valid);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL node_unexpected: idx=%0d issued, none required", bus.node_idx);
        end else begin
            e = exp_q.pop_front();
            if (bus.node_idx !== e.idx || bus.node_range.min !== e.mn || bus.node_range.max !== e.mx) begin
                errors++;
                $display("FAIL node_issue: got idx=%0d min=%0d max=%0d required idx=%0d min=%0d max=%0d",
                         bus.node_idx, bus.node_range.min, bus.node_range.max, e.idx, e.mn, e.mx);
            end
        end
        bus.node_ready = 1'b1;
        cyc();
        bus.node_ready = 1'b0;
    endtask

    task automatic respond(bit hit, bit leaf, int first, int cnt, longint rmin, longint rmax);
        bus.res_valid     = 1'b1;
        bus.res_hit       = hit;
        bus.res_is_leaf   = leaf;
        bus.res_first     = 16'(first);
        bus.res_count     = 4'(cnt);
        bus.res_range.min = t_val_t'(rmin);
        bus.res_range.max = t_val_t'(rmax);
        cyc();
        bus.res_valid = 1'b0;
        bus.res_hit   = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            cyc();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.ray_ready !== 1'b1 || bus.node_valid !== 1'b0 || bus.leaf_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ray_ready=%b node_valid=%b leaf_valid=%b done=%b overflow=%b required 1 0 0 0 0",
                     bus.ray_ready, bus.node_valid, bus.leaf_valid, bus.done, bus.overflow);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (bus.ray_ready !== 1'b1 || bus.node_range !== '0) begin
            errors++;
            $display("FAIL reset_idle: ray_ready=%b node_range=%h required 1 and 0", bus.ray_ready, bus.node_range);
        end
    endtask

    task automatic test_root_miss();
        push_exp(16, 0, 1000);
        start_ray(16, 0, 1000);
        accept_node();
        respond(1'b0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (bus.done !== 1'b0 || bus.leaf_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_pop: done=%b leaf_valid=%b required 0 0", bus.done, bus.leaf_valid);
        end
        cyc();
        checks++;
        if (bus.done !== 1'b1 || bus.leaf_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_done: done=%b leaf_valid=%b required 1 0", bus.done, bus.leaf_valid);
        end
        cyc();
        checks++;
        if (bus.done !== 1'b0 || bus.ray_ready !== 1'b1) begin
            errors++;
            $display("FAIL miss_idle: done=%b ray_ready=%b required 0 1", bus.done, bus.ray_ready);
        end
    endtask

    task automatic test_inner_hit();
        bit seen;
        push_exp(1, 0, 1000);
        start_ray(1, 0, 1000);
        accept_node();
        push_exp(4, 100, 1000);
        respond(1'b1, 1'b0, 4, 0, 100, 900);
        accept_node();
        push_exp(5, 100, 1000);
        respond(1'b0, 1'b0, 0, 0, 0, 0);
        accept_node();
        respond(1'b0, 1'b0, 0, 0, 0, 0);
        wait_done(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL inner_done_timeout: done=%b required 1", bus.done); end
        cyc();
    endtask

    task automatic test_leaf_hold();
        bit seen;
        push_exp(2, 0, 1000);
        start_ray(2, 0, 1000);
        accept_node();
        bus.leaf_ready = 1'b0;
        respond(1'b1, 1'b1, 20, 3, 50, 600);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.leaf_valid !== 1'b1 || bus.leaf_first !== 16'd20 || bus.leaf_count !== 4'd3 ||
                bus.leaf_range.min !== t_val_t'(50) || bus.leaf_range.max !== t_val_t'(600)) begin
                errors++;
                $display("FAIL leaf_hold[%0d]: valid=%b first=%0d count=%0d min=%0d max=%0d required 1 20 3 50 600",
                         k, bus.leaf_valid, bus.leaf_first, bus.leaf_count, bus.leaf_range.min, bus.leaf_range.max);
            end
            cyc();
        end
        bus.leaf_ready = 1'b1;
        cyc();
        bus.leaf_ready = 1'b0;
        checks++;
        if (bus.leaf_valid !== 1'b0) begin errors++; $display("FAIL leaf_release: leaf_valid=%b required 0", bus.leaf_valid); end
        wait_done(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL leaf_done_timeout: done=%b required 1", bus.done); end
        cyc();
    endtask

    task automatic test_cull();
        push_exp(3, 0, 1000);
        start_ray(3, 0, 1000);
        accept_node();
        push_exp(8, 300, 1000);
        respond(1'b1, 1'b0, 8, 0, 300, 900);
        accept_node();
        bus.tclose_valid = 1'b1;
        bus.tclose = t_val_t'(250);
        cyc();
        bus.tclose_valid = 1'b0;
        checks++;
        if (bus.node_range.max !== t_val_t'(250)) begin
            errors++;
            $display("FAIL tclose_load: max=%0d required 250", bus.node_range.max);
        end
        respond(1'b0, 1'b0, 0, 0, 0, 0);
        cyc();
        checks++;
        if (bus.node_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL cull_cycle: node_valid=%b done=%b required 0 0", bus.node_valid, bus.done);
        end
        cyc();
        checks++;
        if (bus.done !== 1'b1 || bus.node_valid !== 1'b0) begin
            errors++;
            $display("FAIL cull_done: done=%b node_valid=%b required 1 0", bus.done, bus.node_valid);
        end
        cyc();
    endtask

    task automatic test_overflow();
        bit seen;
        push_exp(0, 0, 1000);
        start_ray(0, 0, 1000);
        accept_node();
        for (int i = 0; i <= 16; i++) begin
            push_exp(2*i + 2, i, 1000);
            respond(1'b1, 1'b0, 2*i + 2, 0, i, 1000);
            checks++;
            if (bus.overflow !== (i == 16)) begin
                errors++;
                $display("FAIL overflow_push[%0d]: overflow=%b required %0b", i, bus.overflow, (i == 16));
            end
            accept_node();
        end
        respond(1'b0, 1'b0, 0, 0, 0, 0);
        for (int i = 15; i >= 0; i--) begin
            push_exp(2*i + 3, i, 1000);
            accept_node();
            respond(1'b0, 1'b0, 0, 0, 0, 0);
        end
        wait_done(seen);
        checks++;
        if (!seen || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_done: done_seen=%b overflow=%b required 1 1", seen, bus.overflow);
        end
        cyc();
    endtask

    task automatic test_stall_reset();
        push_exp(7, 0, 500);
        start_ray(7, 0, 500);
        bus.node_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.node_valid !== 1'b1 || bus.node_idx !== 16'd7 || bus.node_range.max !== t_val_t'(500)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b idx=%0d max=%0d required 1 7 500",
                         k, bus.node_valid, bus.node_idx, bus.node_range.max);
            end
            cyc();
        end
        accept_node();
        push_exp(30, 10, 500);
        respond(1'b1, 1'b0, 30, 0, 10, 400);
        accept_node();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ray_ready !== 1'b1 || bus.node_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ray_ready=%b node_valid=%b overflow=%b done=%b required 1 0 0 0",
                     bus.ray_ready, bus.node_valid, bus.overflow, bus.done);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        push_exp(40, 0, 100);
        start_ray(40, 0, 100);
        accept_node();
        respond(1'b0, 1'b0, 0, 0, 0, 0);
        cyc();
        checks++;
        if (bus.done !== 1'b1 || bus.node_valid !== 1'b0) begin
            errors++;
            $display("FAIL stack_cleared: done=%b node_valid=%b required 1 0", bus.done, bus.node_valid);
        end
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.ray_valid    = 1'b0;
        bus.root_idx     = '0;
        bus.ray_range    = '0;
        bus.node_ready   = 1'b0;
        bus.res_valid    = 1'b0;
        bus.res_hit      = 1'b0;
        bus.res_range    = '0;
        bus.res_is_leaf  = 1'b0;
        bus.res_first    = '0;
        bus.res_count    = '0;
        bus.leaf_ready   = 1'b0;
        bus.tclose_valid = 1'b0;
        bus.tclose       = '0;
        test_reset();
        test_root_miss();
        test_inner_hit();
        test_leaf_hold();
        test_cull();
        test_overflow();
        test_stall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
